// File: rtl/imm_ext_pkg.sv
// Shared constants for the pipelined immediate extender: class codes,
// instruction-field positions and the input immediate width.
package imm_ext_pkg;

    localparam int CTRL_W   = 3;
    localparam int IMM_IN_W = 26;

    localparam logic [CTRL_W-1:0] IMM_I  = 3'b000;
    localparam logic [CTRL_W-1:0] IMM_D  = 3'b001;
    localparam logic [CTRL_W-1:0] IMM_B  = 3'b010;
    localparam logic [CTRL_W-1:0] IMM_CB = 3'b011;
    localparam logic [CTRL_W-1:0] IMM_IW = 3'b100;

    // I class: imm12 field and the add/sub shift-by-12 bit
    localparam int I_LSB    = 10;
    localparam int I_MSB    = 21;
    localparam int I_SH_BIT = 22;

    // D class: 9-bit signed offset
    localparam int D_LSB = 12;
    localparam int D_MSB = 20;

    // CB class: 19-bit signed word offset
    localparam int CB_LSB = 5;
    localparam int CB_MSB = 23;

    // IW class: 16-bit immediate and 2-bit halfword select
    localparam int IW_LSB    = 5;
    localparam int IW_MSB    = 20;
    localparam int IW_HW_LSB = 21;
    localparam int IW_HW_MSB = 22;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: class code + instruction bits [25:0]
// in, DATA_W-wide extended immediate and an error flag out.
// DATA_W must be 32 or 64.
// Optional macro IMM_ADDSUB_SH12_EN: when defined, the I class honours the
// sh bit and shifts imm12 left by 12.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [CTRL_W-1:0]   ctrl_i,
    input  logic [IMM_IN_W-1:0] imm_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                err_o
);

    logic [1:0] iw_hw;

    assign iw_hw = imm_i[IW_HW_MSB:IW_HW_LSB];

    // Decode the class and build the extended value; illegal classes give 0 with err
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (ctrl_i)
            IMM_I: begin
`ifdef IMM_ADDSUB_SH12_EN
                if (imm_i[I_SH_BIT]) begin
                    result_o = DATA_W'({imm_i[I_MSB:I_LSB], 12'b0});
                end else begin
                    result_o = DATA_W'(imm_i[I_MSB:I_LSB]);
                end
`else
                result_o = DATA_W'(imm_i[I_MSB:I_LSB]);
`endif
            end
            IMM_D:  result_o = DATA_W'($signed(imm_i[D_MSB:D_LSB]));
            IMM_B:  result_o = DATA_W'($signed({imm_i, 2'b00}));
            IMM_CB: result_o = DATA_W'($signed({imm_i[CB_MSB:CB_LSB], 2'b00}));
            IMM_IW: begin
                // A 32-bit datapath cannot place the halfword at bit 32 or 48
                if (DATA_W == 32 && iw_hw[1]) begin
                    err_o = 1'b1;
                end else begin
                    result_o = DATA_W'(imm_i[IW_MSB:IW_LSB]) << {iw_hw, 4'b0000};
                end
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extender with valid/ready on both sides
// and a synchronous flush. S1 registers the raw request, S2 registers the
// extended result and drives the outputs directly, so outputs hold while
// the consumer stalls.
// Optional macro IMM_ADDSUB_SH12_EN (passed through to imm_ext_core).
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [IMM_IN_W-1:0] in_imm,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_imm,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic                s1_valid_q, s1_valid_d;
    logic [CTRL_W-1:0]   s1_ctrl_q,  s1_ctrl_d;
    logic [IMM_IN_W-1:0] s1_imm_q,   s1_imm_d;
    logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;

    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   s2_imm_q,   s2_imm_d;
    logic [TAG_W-1:0]    s2_tag_q,   s2_tag_d;
    logic                s2_err_q,   s2_err_d;

    logic                s2_adv;
    logic                s1_adv;
    logic                s1_free;
    logic                accept;
    logic [DATA_W-1:0]   core_imm;
    logic                core_err;

    imm_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .ctrl_i   (s1_ctrl_q),
        .imm_i    (s1_imm_q),
        .result_o (core_imm),
        .err_o    (core_err)
    );

    // Handshake: S2 can take new data when empty or draining; S1 when empty or moving on
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        s1_free  = !s1_valid_q || s2_adv;
        in_ready = s1_free && !flush;
        accept   = in_valid && in_ready;
    end

    // Next-state for both stages; flush squashes valids regardless of backpressure
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_imm_d   = s1_imm_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;

        if (s1_free) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_ctrl_d = in_ctrl;
            s1_imm_d  = in_imm;
            s1_tag_d  = in_tag;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_imm_d = core_imm;
            s2_tag_d = s1_tag_q;
            s2_err_d = core_err;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_imm_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s1_imm_q   <= s1_imm_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_imm   = s2_imm_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 64-bit and a 32-bit instance share all inputs.
// A scoreboard queue receives expected results on each accepted request and
// is checked on each consumed result.
module tb_imm_extend_pipe;

    localparam int TAG_W = 5;

    logic              CLK;
    logic              resetl;
    logic              in_valid;
    logic              in_ready, in_ready32;
    logic [2:0]        in_ctrl;
    logic [25:0]       in_imm;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_ready;
    logic              out_valid, out_valid32;
    logic [63:0]       out_imm;
    logic [31:0]       out_imm32;
    logic [TAG_W-1:0]  out_tag, out_tag32;
    logic              out_err, out_err32;

    imm_extend_pipe #(.DATA_W(64), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_imm(in_imm), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err)
    );

    imm_extend_pipe #(.DATA_W(32), .TAG_W(TAG_W)) dut32 (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready32),
        .in_ctrl(in_ctrl), .in_imm(in_imm), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_tag(out_tag32), .out_err(out_err32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference model for both widths
    function automatic void model(input logic [2:0] c, input logic [25:0] im,
                                  output logic [63:0] e64, output logic er64,
                                  output logic [31:0] e32, output logic er32);
        logic [63:0] v;
        v = '0; er64 = 1'b0; er32 = 1'b0;
        case (c)
            3'd0: begin
                v = 64'(im[21:10]);
`ifdef IMM_ADDSUB_SH12_EN
                if (im[22]) v = v * 64'd4096;
`endif
            end
            3'd1: v = longint'($signed(im[20:12]));
            3'd2: v = longint'($signed({im, 2'b00}));
            3'd3: v = longint'($signed({im[23:5], 2'b00}));
            3'd4: v = 64'(im[20:5]) * (64'd1 << (16 * im[22:21]));
            default: begin er64 = 1'b1; er32 = 1'b1; end
        endcase
        e64 = v;
        e32 = v[31:0];
        if (c == 3'd4 && im[22]) begin
            er32 = 1'b1;
            e32  = '0;
        end
    endfunction

    typedef struct {
        logic [63:0]      e64;
        logic             er64;
        logic [31:0]      e32;
        logic             er32;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               lat;
    } sb_t;

    sb_t sb[$];

    logic [63:0] cur_e64;
    logic        cur_er64;
    logic [31:0] cur_e32;
    logic        cur_er32;
    bit          lat_check = 0;
    int          ncyc = 0;

    bit               prev_stall = 0;
    logic [63:0]      prev_imm;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;

    always @(negedge resetl) begin
        sb.delete();
        prev_stall = 0;
    end

    // Monitor: everything here is stable until the next rising edge
    always @(negedge CLK) begin
        sb_t it;
        ncyc++;
        if (resetl) begin
            if (prev_stall && out_valid) begin
                chk("hold_imm", out_imm, prev_imm);
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
                chk("hold_err", 64'(out_err), 64'(prev_err));
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_imm   = out_imm;
            prev_tag   = out_tag;
            prev_err   = out_err;

            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got tag %0h with empty scoreboard", out_tag);
                    end else begin
                        it = sb.pop_front();
                        chk("imm64", out_imm, it.e64);
                        chk("err64", 64'(out_err), 64'(it.er64));
                        chk("tag64", 64'(out_tag), 64'(it.tag));
                        chk("valid32", 64'(out_valid32), 64'd1);
                        chk("imm32", 64'(out_imm32), 64'(it.e32));
                        chk("err32", 64'(out_err32), 64'(it.er32));
                        chk("tag32", 64'(out_tag32), 64'(it.tag));
                        if (it.lat) chk("latency", 64'(ncyc - it.cyc), 64'd2);
                    end
                end
                if (in_valid && in_ready) begin
                    it.e64 = cur_e64; it.er64 = cur_er64;
                    it.e32 = cur_e32; it.er32 = cur_er32;
                    it.tag = in_tag;  it.cyc  = ncyc; it.lat = lat_check;
                    sb.push_back(it);
                end
            end
        end
    end

    task automatic apply(input logic [2:0] c, input logic [25:0] im, input logic [TAG_W-1:0] tg,
                         input logic [63:0] e64, input logic er64,
                         input logic [31:0] e32, input logic er32);
        in_valid = 1'b1; in_ctrl = c; in_imm = im; in_tag = tg;
        cur_e64 = e64; cur_er64 = er64; cur_e32 = e32; cur_er32 = er32;
    endtask

    task automatic apply_model(input logic [2:0] c, input logic [25:0] im, input logic [TAG_W-1:0] tg);
        logic [63:0] e64; logic er64; logic [31:0] e32; logic er32;
        model(c, im, e64, er64, e32, er32);
        apply(c, im, tg, e64, er64, e32, er32);
    endtask

    // Called at posedge+1 with a request applied; returns at posedge+1 after acceptance
    task automatic wait_acc(input bit rnd_bp);
        bit acc;
        acc = 0;
        for (int k = 0; k < 60 && !acc; k++) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            @(posedge CLK); #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [25:0] im;
        logic [63:0] e64;
        logic        er64;
        logic [31:0] e32;
        logic        er32;
    } vec_t;

`ifdef IMM_ADDSUB_SH12_EN
    localparam logic [63:0] SH_EXP = 64'h0000000000001000;
`else
    localparam logic [63:0] SH_EXP = 64'h0000000000000001;
`endif

    vec_t vecs[14];

    initial begin
        int idx;
        logic [63:0] held;

        vecs[0]  = '{3'd0, 26'h03FFC00, 64'h0000000000000FFF, 1'b0, 32'h00000FFF, 1'b0};
        vecs[1]  = '{3'd1, 26'h0100000, 64'hFFFFFFFFFFFFFF00, 1'b0, 32'hFFFFFF00, 1'b0};
        vecs[2]  = '{3'd2, 26'h3FFFFFF, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{3'd3, 26'h0800000, 64'hFFFFFFFFFFF00000, 1'b0, 32'hFFF00000, 1'b0};
        vecs[4]  = '{3'd4, 26'h057DDE0, 64'h0000BEEF00000000, 1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{3'd7, 26'h3FFFFFF, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b1};
        vecs[6]  = '{3'd0, 26'h0400400, SH_EXP,               1'b0, SH_EXP[31:0], 1'b0};
        vecs[7]  = '{3'd4, 26'h0024680, 64'h0000000000001234, 1'b0, 32'h00001234, 1'b0};
        vecs[8]  = '{3'd4, 26'h0300020, 64'h0000000080010000, 1'b0, 32'h80010000, 1'b0};
        vecs[9]  = '{3'd4, 26'h07FFFE0, 64'hFFFF000000000000, 1'b0, 32'h00000000, 1'b1};
        vecs[10] = '{3'd1, 26'h00FF000, 64'h00000000000000FF, 1'b0, 32'h000000FF, 1'b0};
        vecs[11] = '{3'd5, 26'h0000000, 64'h0000000000000000, 1'b1, 32'h00000000, 1'b1};
        vecs[12] = '{3'd3, 26'h07FFFE0, 64'h00000000000FFFFC, 1'b0, 32'h000FFFFC, 1'b0};
        vecs[13] = '{3'd2, 26'h1FFFFFF, 64'h0000000007FFFFFC, 1'b0, 32'h07FFFFFC, 1'b0};

        resetl = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_imm = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        cur_e64 = '0; cur_er64 = 1'b0; cur_e32 = '0; cur_er32 = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        @(negedge CLK);
        resetl = 1'b1;
        @(posedge CLK); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table vectors back to back, no backpressure, latency checked
        lat_check = 1;
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].c, vecs[i].im, TAG_W'(i + 1), vecs[i].e64, vecs[i].er64,
                  vecs[i].e32, vecs[i].er32);
            wait_acc(0);
        end
        drain();
        lat_check = 0;

        // Backpressure: 5 stalled cycles with 4 requests offered
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            apply_model(3'd4, 26'h0024680 + 26'(idx * 32), TAG_W'(16 + idx));
            @(negedge CLK);
            if (in_ready) idx++;
            @(posedge CLK); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        held = out_imm;
        @(posedge CLK); #1;
        chk("bp_held_imm", out_imm, held);
        out_ready = 1'b1;
        while (idx < 4) begin
            apply_model(3'd4, 26'h0024680 + 26'(idx * 32), TAG_W'(16 + idx));
            wait_acc(0);
            idx++;
        end
        drain();

        // Flush with both stages full, backpressure and a request pending
        out_ready = 1'b0;
        apply_model(3'd1, 26'h0155000, 5'd20);
        wait_acc(0);
        apply_model(3'd2, 26'h2000001, 5'd21);
        wait_acc(0);
        apply_model(3'd3, 26'h0123460, 5'd22);
        @(negedge CLK);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK); #1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_valid32", 64'(out_valid32), 64'd0);
        out_ready = 1'b1;
        wait_acc(0);
        drain();

        // Asynchronous reset with entries in flight
        out_ready = 1'b0;
        apply_model(3'd0, 26'h03FFC00, 5'd23);
        wait_acc(0);
        apply_model(3'd4, 26'h057DDE0, 5'd24);
        wait_acc(0);
        in_valid = 1'b0;
        @(negedge CLK); #2;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        resetl = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_imm", out_imm, 64'd0);
        chk("mid_rst_tag", 64'(out_tag), 64'd0);
        chk("mid_rst_err", 64'(out_err), 64'd0);
        @(negedge CLK);
        resetl = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Random traffic with random backpressure
        for (int n = 0; n < 80; n++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge CLK); #1;
            end
            apply_model(3'($urandom_range(0, 7)), 26'($urandom), TAG_W'($urandom));
            wait_acc(1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
